disp_arbiter: RTL and testbench

Round-robin scheduler that shares the single two-digit decimal display path (4-bit value → tens/ones seven-segment conversion) between several 4-bit requesters. Each granted requester owns the display for a fixed minimum hold period, so every value stays readable. The block registers the winning requester's value and drives it onto the shared `V[3:0]` input of the conversion path. It also reports the current owner on the board LEDs.

---
 rtl/disp_pkg.sv | 21 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/disp_arbiter.sv | 140 ++++++++++++++
 tb/tb_disp_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter.
package disp_pkg;

  // Arbiter states: no owner, or a requester owns the display.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Largest supported requester count; also fixes the 3-bit index width.
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = 3;

  // Hold counter width: enough bits for HOLD_CYCLES-1, never below 1.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles);
    int unsigned w;
    w = $clog2(hold_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req from start upward with wrap,
// optionally skipping one index, and returns the first hit.
module rr_pick
  import disp_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_NREQ-1:0] req_ext;

  // Zero-pad so any 3-bit index is in range.
  assign req_ext = MAX_NREQ'(req);

  // Priority scan starting at start, wrapping at NREQ; first match wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      sum = {1'b0, start} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NREQ)) begin
        sum = sum - (IDX_W + 1)'(NREQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req_ext[cand] && !(excl_en && (cand == excl_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner of the shared two-digit display path. A granted requester
// keeps the display for HOLD_CYCLES cycles; its value is registered onto V.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   data,
  output logic [NREQ-1:0]     grant,
  output logic [3:0]          V,
  output logic                valid,
  output logic [IDX_W-1:0]    owner
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [3:0]       v_q, v_d;

  logic [3:0]       slice [MAX_NREQ];
  logic [IDX_W-1:0] pick_start;
  logic             pick_excl;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // Unpack data into per-requester nibbles; unused entries read as zero.
  for (genvar g = 0; g < int'(MAX_NREQ); g++) begin : g_slice
    if (g < int'(NREQ)) begin : g_used
      assign slice[g] = data[4*g +: 4];
    end else begin : g_pad
      assign slice[g] = 4'd0;
    end
  end

  // Search origin: after last in IDLE, after owner (skipping it) at expiry.
  always_comb begin
    pick_start = '0;
    pick_excl  = 1'b0;
    if (state_q == IDLE) begin
      pick_start = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
    end else begin
      pick_start = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
      pick_excl  = 1'b1;
    end
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req      (req),
    .start    (pick_start),
    .excl_en  (pick_excl),
    .excl_idx (owner_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Next-state logic: grant decisions, hold countdown and live value tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        v_d = 4'd0;
        if (pick_found) begin
          state_d = HOLD;
          owner_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = RELOAD;
          v_d     = slice[pick_idx];
        end
      end
      HOLD: begin
        v_d   = slice[owner_q];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (pick_found) begin
            // Handover with no gap: new owner's value loads on this edge.
            owner_d = pick_idx;
            last_d  = pick_idx;
            cnt_d   = RELOAD;
            v_d     = slice[pick_idx];
          end else if (req[owner_q]) begin
            last_d = owner_q;
            cnt_d  = RELOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            v_d     = 4'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_IDX;
      owner_q <= '0;
      v_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      v_q     <= v_d;
    end
  end

  // One-hot grant decode of the current owner; all zero when idle.
  always_comb begin
    grant = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      grant[i] = (state_q == HOLD) && (owner_q == IDX_W'(i));
    end
  end

  assign valid = (state_q == HOLD);
  assign owner = owner_q;
  assign V     = v_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with NREQ=4, HOLD_CYCLES=4.
module tb_disp_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned HOLD = 4;

  logic              Clock;
  logic              Reset;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] data;
  logic [NREQ-1:0]   grant;
  logic [3:0]        V;
  logic              valid;
  logic [2:0]        owner;

  int errors = 0;
  int checks = 0;

  disp_arbiter #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .req   (req),
    .data  (data),
    .grant (grant),
    .V     (V),
    .valid (valid),
    .owner (owner)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_own(input string tag, input logic [3:0] g, input logic [3:0] v);
    chk({tag, "_grant"}, 8'(grant), 8'(g));
    chk({tag, "_valid"}, 8'(valid), 8'(g != 4'd0));
    chk({tag, "_V"}, 8'(V), 8'(v));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    req   = '0;
    data  = '0;
    tick();
    tick();
    chk_own("reset", 4'b0000, 4'd0);
    chk("reset_owner", 8'(owner), 8'd0);
    Reset = 1'b0;

    // Single requester with re-grant across expiry.
    req  = 4'b0001;
    data = 16'h0007;
    tick();
    chk_own("single_first", 4'b0001, 4'd7);
    chk("single_owner", 8'(owner), 8'd0);
    for (int c = 0; c < 4; c++) tick();
    chk_own("single_regrant", 4'b0001, 4'd7);
    tick();
    chk_own("single_regrant2", 4'b0001, 4'd7);

    // Rotation across all four, 4 cycles each, no gaps; then wrap to 0.
    do_reset();
    req  = 4'b1111;
    data = {4'd12, 4'd11, 4'd10, 4'd9};
    tick();
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 4; c++) begin
        chk_own($sformatf("rot_o%0d_c%0d", o, c), 4'(1 << o), 4'(9 + o));
        // During owner 3's hold only 0 and 3 keep requesting.
        if (o == 3 && c == 0) req = 4'b1001;
        tick();
      end
    end
    chk_own("wrap_to_0", 4'b0001, 4'd9);
    chk("wrap_owner", 8'(owner), 8'd0);
    for (int c = 0; c < 4; c++) tick();
    chk_own("fair_to_3", 4'b1000, 4'd12);
    chk("fair_owner", 8'(owner), 8'd3);

    // Early drop: ownership kept for the full hold, then idle.
    do_reset();
    req  = 4'b0100;
    data = 16'h0500;
    tick();
    req = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      chk_own($sformatf("drop_c%0d", c), 4'b0100, 4'd5);
      tick();
    end
    chk_own("drop_idle", 4'b0000, 4'd0);

    // Live data tracking for owner 1.
    do_reset();
    req  = 4'b0010;
    data = 16'h0030;
    tick();
    chk_own("live_c1", 4'b0010, 4'd3);
    tick();
    chk_own("live_c2", 4'b0010, 4'd3);
    data = 16'h00F0;
    tick();
    chk_own("live_c3", 4'b0010, 4'd15);

    // Asynchronous reset mid-hold, then a fresh grant one cycle after release.
    #3;
    Reset = 1'b1;
    #1;
    chk_own("async_rst", 4'b0000, 4'd0);
    chk("async_owner", 8'(owner), 8'd0);
    #1;
    Reset = 1'b0;
    tick();
    chk_own("after_rst", 4'b0010, 4'd15);
    chk("after_rst_owner", 8'(owner), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
